// File: rtl/overlap_mc.sv
// Purpose: IMDCT overlap-add for CHANNELS independent streams. Each frame has 2*HALF samples:
//          the first half is added to the stored overlap and emitted as saturated PCM, the second half is stored.
// Latency: 1 cycle from an accepted first-half sample to its PCM output. Backpressure: one output register; in_ready drops only while it is full and stalled.
module overlap_mc #(
  parameter int IN_W     = 32,
  parameter int OUT_W    = 16,
  parameter int HALF     = 64,
  parameter int CHANNELS = 2,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_sample,
  input  logic [CH_W-1:0]         in_channel,
  input  logic                    in_first,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_sample,
  output logic [CH_W-1:0]         out_channel,
  output logic                    out_last,
  output logic                    busy
);

  localparam int IW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(HALF - 1);

  // Saturation limits expressed at the IN_W+1 sum width.
  localparam logic signed [IN_W:0] SAT_MAX = {{(IN_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [IN_W:0] SAT_MIN = {{(IN_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    STORE = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [IW-1:0]           idx;
  logic [IW-1:0]           idx_nxt;
  logic [CH_W-1:0]         ch;
  logic                    first;
  logic [CHANNELS-1:0]     primed;
  logic                    set_primed;

  // Overlap storage is never reset; primed flags decide whether it is read.
  logic signed [IN_W-1:0]  ovl_mem [CHANNELS][HALF];

  logic                    in_fire;
  logic                    add_fire;
  logic [CH_W-1:0]         cur_ch;
  logic                    cur_first;
  logic                    ch_ok;
  logic                    use_ovl;
  logic signed [IN_W-1:0]  ovl;
  logic signed [IN_W:0]    sum;
  logic signed [OUT_W-1:0] sat_val;

  // The first sample of a frame arrives in IDLE, before channel/first are latched,
  // so it is processed using the live inputs.
  assign cur_ch    = (state == IDLE) ? in_channel : ch;
  assign cur_first = (state == IDLE) ? in_first : first;
  assign ch_ok     = (int'(cur_ch) < CHANNELS);

  // STORE never touches the output register, so it can always accept. IDLE and ADD
  // both load the output register and therefore share its full/stall condition;
  // this keeps a PCM sample still stalled from the previous frame from being overwritten.
  assign in_ready = (state == STORE) ? 1'b1 : (!out_valid || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign add_fire = in_fire && (state != STORE);

  assign use_ovl = ch_ok && primed[cur_ch] && !cur_first;
  assign ovl     = use_ovl ? ovl_mem[cur_ch][idx] : '0;
  assign sum     = {in_sample[IN_W-1], in_sample} + {ovl[IN_W-1], ovl};

  assign busy = (state != IDLE) || out_valid;

  // Clamp the widened sum into the PCM range; no scaling or rounding.
  always_comb begin
    sat_val = sum[OUT_W-1:0];
    if (sum > SAT_MAX) begin
      sat_val = SAT_MAX[OUT_W-1:0];
    end else if (sum < SAT_MIN) begin
      sat_val = SAT_MIN[OUT_W-1:0];
    end
  end

  // Next-state and index sequencing through the two half-frames.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    set_primed = 1'b0;
    case (state)
      IDLE, ADD: begin
        if (in_fire) begin
          if (idx == LAST_IDX) begin
            state_nxt = STORE;
            idx_nxt   = '0;
          end else begin
            state_nxt = ADD;
            idx_nxt   = idx + 1'b1;
          end
        end
      end
      STORE: begin
        if (in_fire) begin
          if (idx == LAST_IDX) begin
            state_nxt  = IDLE;
            idx_nxt    = '0;
            set_primed = ch_ok;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // State, index, per-frame channel context and primed flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      idx    <= '0;
      ch     <= '0;
      first  <= 1'b0;
      primed <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if ((state == IDLE) && in_fire) begin
        ch    <= in_channel;
        first <= in_first;
      end
      if (set_primed) begin
        primed[ch] <= 1'b1;
      end
    end
  end

  // Second-half samples are kept verbatim for the next frame on this channel.
  always_ff @(posedge clk) begin
    if (reset && in_fire && (state == STORE) && ch_ok) begin
      ovl_mem[ch][idx] <= in_sample;
    end
  end

  // Single output register: loads on every first-half sample, drains on out_ready.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid   <= 1'b0;
      out_sample  <= '0;
      out_channel <= '0;
      out_last    <= 1'b0;
    end else if (add_fire) begin
      out_valid   <= 1'b1;
      out_sample  <= sat_val;
      out_channel <= cur_ch;
      out_last    <= (idx == LAST_IDX);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
